sync_fifo_ext: RTL and testbench
================================

Name: sync_fifo_ext

Overview:
Next-generation parametrised synchronous FIFO for the median-filter line buffers and stream decoupling.
- Adds standard or first-word-fall-through (FWFT) read mode, a live data count, and programmable almost-full/almost-empty flags.
- Adds per-cycle overflow/underflow error pulses.
- Single clock domain. Sits between pixel producers (window/line logic) and consumers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 2048, storage words; power of two, >=4
FWFT, 0, 0 = standard read (data 1 cycle after rd_en); 1 = first-word-fall-through
AFULL_THRESH, DEPTH-4, almost_full asserts when dcnt >= this value (1..DEPTH)
AEMPTY_THRESH, 4, almost_empty asserts when dcnt <= this value (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  WIDTH  write data
wr_en  input  1  write request
full  output  1  dcnt == DEPTH
almost_full  output  1  dcnt >= AFULL_THRESH
overflow  output  1  one-cycle pulse: wr_en while full
dout  output  WIDTH  read data
rd_en  input  1  read request (standard) / pop acknowledge (FWFT)
empty  output  1  no readable word
almost_empty  output  1  dcnt <= AEMPTY_THRESH
underflow  output  1  one-cycle pulse: rd_en while empty
dcnt  output  $clog2(DEPTH)+1  words held, 0..DEPTH

Behaviour:
- Storage: DEPTH x WIDTH array, synchronous read, no reset on contents.
- Pointers: $clog2(DEPTH)+1 bits each; the extra MSB disambiguates full from empty. Pointers wrap naturally at DEPTH.
- Reset (rst=1 at an edge; also aborts any operation in flight):
  - Pointers = 0, dcnt = 0, full = 0, empty = 1.
  - almost_full = 0, almost_empty = 1, overflow = 0, underflow = 0, dout = 0.
  - Any FWFT prefetch register is invalidated.
- Write acceptance: wr_en && !full stores din at wr_ptr. wr_ptr++.
  - wr_en && full: write dropped, no state change, overflow = 1 next cycle.
  - A write is never accepted on a full FIFO, even when rd_en is asserted in the same cycle.
- Standard mode (FWFT=0):
  - Read acceptance: rd_en && !empty. dout updates to the head word on the next rising edge, 1-cycle latency. rd_ptr++.
  - dout holds its last value when no read is accepted.
  - rd_en && empty: ignored, underflow = 1 next cycle.
  - empty deasserts the cycle after the first accepted write.
- FWFT mode (FWFT=1):
  - An internal output register holds the head word. empty = !valid.
  - A write into an empty FIFO at edge N gives dout valid and empty = 0 after edge N+2 (memory read + load).
  - rd_en && !empty pops the head. If the next word exists, dout shows it after the following edge, with no bubble for back-to-back pops.
  - rd_en && empty: underflow pulse.
- dcnt: count of all words held, including the FWFT output register.
  - Accepted write only: +1. Accepted read only: -1. Both accepted: unchanged.
  - full, almost_full and almost_empty are registered, derived from the next-state count.
- Simultaneous events:
  - Both accepted: both pointers advance.
  - Write and read on empty: write accepted, read ignored with underflow.
  - Write and read on full: read accepted, write dropped with overflow.
- Elaboration: DEPTH not a power of two, or a threshold out of range, triggers a $error in a generate check.

Optional Feature:
Macro SYNC_FIFO_EXT_PARITY_EN.
- Defined:
  - Each word is stored with one even-parity bit, so the array is WIDTH+1 wide.
  - Parity is checked on every word delivered to dout.
  - Extra output port perr (1 bit, reset 0) pulses high for one cycle, coincident with the bad word on dout.
- Undefined: no parity storage, no perr port, array WIDTH wide.

Test Plan:
1. Reset then idle -> empty=1, full=0, dcnt=0, almost_empty=1, dout=0.
2. DEPTH=16, FWFT=0: write 0x00..0x0F, then 17th write 0xAA -> full=1 after 16th write, dcnt=16, overflow pulse on 17th write. Then 16 reads -> dout 0x00..0x0F in order, 1-cycle latency, 0xAA absent.
3. FWFT=1, single write 0x5C at edge N -> empty=0 and dout=0x5C after edge N+2. Pop -> empty=1, dcnt=0.
4. Full FIFO with wr_en=rd_en=1 -> read accepted, write dropped, overflow=1, dcnt 16->15. Empty FIFO with wr_en=rd_en=1 -> write accepted, underflow=1, dcnt 0->1.
5. 40 simultaneous read/write cycles at dcnt=8 with DEPTH=16 (pointers wrap twice) -> dcnt stays 8, data order preserved. With AFULL_THRESH=12 and AEMPTY_THRESH=4: almost_full rises when dcnt reaches 12, almost_empty rises when dcnt falls to 4.
6. Assert rst mid-burst with dcnt=10 -> next cycle dcnt=0, empty=1. The first subsequent write/read returns the new data, not stale data.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// rtl/sync_fifo_ext.sv - parametrised synchronous FIFO with standard/FWFT read, count and level flags
// Optional build macro SYNC_FIFO_EXT_PARITY_EN adds per-word even parity and the perr output.
module sync_fifo_ext #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 2048,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [WIDTH-1:0]         dout,
  input  logic                     rd_en,
  output logic                     empty,
  output logic                     almost_empty,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   dcnt
`ifdef SYNC_FIFO_EXT_PARITY_EN
  ,
  output logic                     perr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef SYNC_FIFO_EXT_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo_ext: DEPTH must be a power of two and >= 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_afull_chk
    $error("sync_fifo_ext: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_aempty_chk
    $error("sync_fifo_ext: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] mem_rdata_q;
  logic [MW-1:0] wr_word;

  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, dcnt_q, dcnt_d;
  logic          full_q, full_d, almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d, empty_q, empty_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [MW-1:0] out_word_q, out_word_d;
  logic          wr_acc, pop, mem_rd, load_out, empty_int;

`ifdef SYNC_FIFO_EXT_PARITY_EN
  assign wr_word = {^din, din};
`else
  assign wr_word = din;
`endif

  always_comb begin
    empty_int   = (FWFT != 0) ? !out_valid_q : empty_q;
    wr_acc      = wr_en && !full_q;
    pop         = rd_en && !empty_int;
    mem_rd      = 1'b0;
    load_out    = 1'b0;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    // FWFT: two-stage prefetch (memory read register, then output register) keeps pops bubble-free
    if (FWFT != 0) begin
      load_out = (!out_valid_q || pop) && s1_valid_q;
      if (load_out) begin
        out_valid_d = 1'b1;
        out_word_d  = mem_rdata_q;
      end else if (pop) begin
        out_valid_d = 1'b0;
      end
      mem_rd = (!s1_valid_q || load_out) && (wr_ptr_q != rd_ptr_q);
      if (mem_rd) begin
        s1_valid_d = 1'b1;
      end else if (load_out) begin
        s1_valid_d = 1'b0;
      end
    end else begin
      mem_rd = pop;
    end
    wr_ptr_d       = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d       = rd_ptr_q + CW'(mem_rd);
    dcnt_d         = dcnt_q + CW'(wr_acc) - CW'(pop);
    full_d         = (dcnt_d == CW'(DEPTH));
    almost_full_d  = (dcnt_d >= CW'(AFULL_THRESH));
    almost_empty_d = (dcnt_d <= CW'(AEMPTY_THRESH));
    empty_d        = (dcnt_d == '0);
    overflow_d     = wr_en && full_q;
    underflow_d    = rd_en && empty_int;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

  // Synchronous-read register; doubles as dout in standard mode, hence the reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata_q <= '0;
    end else if (mem_rd) begin
      mem_rdata_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      dcnt_q         <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      empty_q        <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      s1_valid_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_word_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      dcnt_q         <= dcnt_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      empty_q        <= empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      s1_valid_q     <= s1_valid_d;
      out_valid_q    <= out_valid_d;
      out_word_q     <= out_word_d;
    end
  end

`ifdef SYNC_FIFO_EXT_PARITY_EN
  logic          deliver_q, deliver_d;
  logic [MW-1:0] cur_word;

  always_comb begin
    deliver_d = (FWFT != 0) ? load_out : mem_rd;
    cur_word  = (FWFT != 0) ? out_word_q : mem_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deliver_q <= 1'b0;
    end else begin
      deliver_q <= deliver_d;
    end
  end

  // Even parity over data+parity bit must be zero for a good word
  assign perr = deliver_q && (^cur_word);
`endif

  assign dout         = (FWFT != 0) ? out_word_q[WIDTH-1:0] : mem_rdata_q[WIDTH-1:0];
  assign empty        = empty_int;
  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign dcnt         = dcnt_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb/tb_sync_fifo_ext.sv - directed self-checking bench for sync_fifo_ext (standard and FWFT instances)
module tb_sync_fifo_ext;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_din = '0, f_din = '0;
  logic       s_wr = 1'b0, s_rd = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] s_dout, f_dout;
  logic       s_full, s_afull, s_ovf, s_empty, s_aempty, s_unf;
  logic       f_full, f_afull, f_ovf, f_empty, f_aempty, f_unf;
  logic [4:0] s_dcnt, f_dcnt;
`ifdef SYNC_FIFO_EXT_PARITY_EN
  logic       s_perr, f_perr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_std (
    .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr), .full(s_full), .almost_full(s_afull),
    .overflow(s_ovf), .dout(s_dout), .rd_en(s_rd), .empty(s_empty), .almost_empty(s_aempty),
    .underflow(s_unf), .dcnt(s_dcnt)
`ifdef SYNC_FIFO_EXT_PARITY_EN
    , .perr(s_perr)
`endif
  );

  sync_fifo_ext #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_fwft (
    .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .full(f_full), .almost_full(f_afull),
    .overflow(f_ovf), .dout(f_dout), .rd_en(f_rd), .empty(f_empty), .almost_empty(f_aempty),
    .underflow(f_unf), .dcnt(f_dcnt)
`ifdef SYNC_FIFO_EXT_PARITY_EN
    , .perr(f_perr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_empty", 32'(s_empty), 1);
    check("rst_full", 32'(s_full), 0);
    check("rst_dcnt", 32'(s_dcnt), 0);
    check("rst_aempty", 32'(s_aempty), 1);
    check("rst_afull", 32'(s_afull), 0);
    check("rst_dout", 32'(s_dout), 0);
    check("rst_ovf_unf", {s_ovf, s_unf}, 0);
    check("rst_f_empty", 32'(f_empty), 1);
    check("rst_f_dout", 32'(f_dout), 0);

    // Fill standard FIFO, then overflow attempt
    s_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_din = 8'(i);
      step();
      check("fill_dcnt", 32'(s_dcnt), 32'(i + 1));
      check("fill_afull", 32'(s_afull), 32'((i + 1) >= 12));
      check("fill_aempty", 32'(s_aempty), 32'((i + 1) <= 4));
      if (i == 0) check("first_wr_empty", 32'(s_empty), 0);
    end
    check("full_after16", 32'(s_full), 1);
    s_din = 8'hAA;
    step();
    check("ovf_pulse", 32'(s_ovf), 1);
    check("ovf_dcnt", 32'(s_dcnt), 16);
    s_wr = 1'b0;
    step();
    check("ovf_clear", 32'(s_ovf), 0);

    s_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("rd_dout", 32'(s_dout), 32'(i));
      check("rd_dcnt", 32'(s_dcnt), 32'(15 - i));
      check("rd_aempty", 32'(s_aempty), 32'((15 - i) <= 4));
    end
    check("drained_empty", 32'(s_empty), 1);
    step();
    check("unf_pulse", 32'(s_unf), 1);
    check("unf_dout_hold", 32'(s_dout), 32'h0F);
    s_rd = 1'b0;
    step();
    check("unf_clear", 32'(s_unf), 0);

    // Simultaneous on full, then on empty
    s_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_din = 8'(8'h20 + i);
      step();
    end
    s_rd = 1'b1;
    s_din = 8'h77;
    step();
    check("fullrw_ovf", 32'(s_ovf), 1);
    check("fullrw_dcnt", 32'(s_dcnt), 15);
    check("fullrw_dout", 32'(s_dout), 32'h20);
    s_wr = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      check("fullrw_drain", 32'(s_dout), 32'(8'h20 + i));
    end
    check("fullrw_dcnt0", 32'(s_dcnt), 0);
    s_wr = 1'b1;
    s_din = 8'h99;
    step();
    check("emptyrw_unf", 32'(s_unf), 1);
    check("emptyrw_dcnt", 32'(s_dcnt), 1);
    check("emptyrw_dout", 32'(s_dout), 32'h2F);
    s_wr = 1'b0;
    step();
    check("emptyrw_read", 32'(s_dout), 32'h99);
    s_rd = 1'b0;

    // Steady-state streaming at dcnt=8, pointers wrap
    s_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_din = 8'(8'h40 + i);
      step();
    end
    s_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_din = 8'(8'h48 + i);
      step();
      check("stream_dout", 32'(s_dout), 32'(8'h40 + i));
      check("stream_dcnt", 32'(s_dcnt), 8);
    end
    s_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("tail_dout", 32'(s_dout), 32'(8'h68 + k));
      check("tail_aempty", 32'(s_aempty), 32'((7 - k) <= 4));
    end
    s_rd = 1'b0;

    // FWFT single-word latency and pop
    f_wr = 1'b1;
    f_din = 8'h5C;
    step();
    f_wr = 1'b0;
    check("fwft_n_empty", 32'(f_empty), 1);
    check("fwft_n_dcnt", 32'(f_dcnt), 1);
    step();
    check("fwft_n1_empty", 32'(f_empty), 1);
    step();
    check("fwft_n2_empty", 32'(f_empty), 0);
    check("fwft_n2_dout", 32'(f_dout), 32'h5C);
    f_rd = 1'b1;
    step();
    check("fwft_pop_empty", 32'(f_empty), 1);
    check("fwft_pop_dcnt", 32'(f_dcnt), 0);
    step();
    check("fwft_unf", 32'(f_unf), 1);
    f_rd = 1'b0;

    // FWFT back-to-back pops
    f_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_din = 8'(8'h60 + i);
      step();
    end
    f_wr = 1'b0;
    step();
    step();
    check("fwft_b2b_head", 32'(f_dout), 32'h60);
    check("fwft_b2b_dcnt", 32'(f_dcnt), 5);
    f_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fwft_b2b_dout", 32'(f_dout), 32'(8'h61 + i));
      check("fwft_b2b_empty", 32'(f_empty), 0);
    end
    step();
    check("fwft_b2b_last", {f_empty, 3'b0, f_dcnt}, 32'h100);
    f_rd = 1'b0;

    // FWFT full with simultaneous read/write
    f_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f_din = 8'(8'hD0 + i);
      step();
    end
    check("fwft_full", 32'(f_full), 1);
    f_wr = 1'b0;
    step();
    step();
    f_wr = 1'b1;
    f_rd = 1'b1;
    f_din = 8'hEE;
    step();
    check("fwft_fullrw_ovf", 32'(f_ovf), 1);
    check("fwft_fullrw_dcnt", 32'(f_dcnt), 15);
    check("fwft_fullrw_dout", 32'(f_dout), 32'hD1);
    f_wr = 1'b0;
    f_rd = 1'b0;

    // Reset mid-burst
    s_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_din = 8'(8'h80 + i);
      step();
    end
    check("burst_dcnt", 32'(s_dcnt), 10);
    s_din = 8'h8A;
    rst = 1'b1;
    step();
    check("midrst_dcnt", 32'(s_dcnt), 0);
    check("midrst_empty", 32'(s_empty), 1);
    check("midrst_dout", 32'(s_dout), 0);
    check("midrst_f_dcnt", 32'(f_dcnt), 0);
    rst = 1'b0;
    s_din = 8'hC3;
    step();
    check("postrst_dcnt", 32'(s_dcnt), 1);
    s_wr = 1'b0;
    s_rd = 1'b1;
    step();
    check("postrst_dout", 32'(s_dout), 32'hC3);
    check("postrst_empty", 32'(s_empty), 1);
    s_rd = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
